// File: rtl/procesar_disparo.sv
// procesar_disparo: shot processing for a 5x5 naval battle board.
//
// Once the opponent board is placed (disparoHabilitado=1) the block snapshots
// the board, then accepts one shot per rising edge of the fire button,
// classifies it (miss / hit / sunk / invalid), updates the shot map and the
// remaining-cell counters, and reports the outcome as one-cycle pulses.
//
// Ports
//   clk                in   single clock, everything on posedge
//   reset              in   synchronous, active-high
//   disparoHabilitado  in   level, enables the firing phase
//   disparar           in   fire button (level, may be held)
//   fila, columna      in   [3:0] target coordinates, valid 0..4
//   matrizJ            in   [4:0][4:0][31:0] opponent board (0 water, k = ship length)
//   matrizDisparosJ    out  [4:0][4:0][31:0] shot map (0 none, 1 miss, 2 hit, 3 sunk)
//   resultadoValido, impacto, agua, hundido, disparoInvalido
//                      out  one-cycle result pulses
//   tipoHundido        out  [2:0] length of the ship just sunk (valid with hundido)
//   celdasRestantes    out  [3:0] un-hit ship cells remaining
//   disparosRealizados out  [4:0] accepted shots
//   juegoTerminado     out  level, all ship cells hit
module procesar_disparo (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   disparoHabilitado,
  input  logic                   disparar,
  input  logic [3:0]             fila,
  input  logic [3:0]             columna,
  input  logic [4:0][4:0][31:0]  matrizJ,
  output logic [4:0][4:0][31:0]  matrizDisparosJ,
  output logic                   resultadoValido,
  output logic                   impacto,
  output logic                   agua,
  output logic                   hundido,
  output logic                   disparoInvalido,
  output logic [2:0]             tipoHundido,
  output logic [3:0]             celdasRestantes,
  output logic [4:0]             disparosRealizados,
  output logic                   juegoTerminado
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EVAL,
    S_REPORT,
    S_DONE
  } state_t;

  state_t                 state;
  logic                   disparar_prev;
  logic [3:0]             row_q;
  logic [3:0]             col_q;
  logic [4:0][4:0][2:0]   board_q;  // normalised snapshot, 0 or ship length 1..5
  logic [4:0][4:0][1:0]   map_q;    // shot map, widened to 32 bits at the port
  logic [7:0][4:0]        rest_q;   // un-hit cells per ship length, index = length

  // Board values outside 1..5 (including negative ints) count as water.
  function automatic logic [2:0] norm_cell(input logic [31:0] v);
    if (v >= 32'd1 && v <= 32'd5) return v[2:0];
    return 3'd0;
  endfunction

  // Snapshot and per-length census of the incoming board, used in LOAD.
  logic [4:0][4:0][2:0]   load_board;
  logic [7:0][4:0]        load_cnt;
  logic [6:0]             load_total;
  logic [3:0]             load_cells;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_board = '0;
    load_cnt   = '0;
    load_total = 7'd0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        load_board[i][j] = norm_cell(matrizJ[i][j]);
        if (load_board[i][j] != 3'd0)
          load_cnt[load_board[i][j]] = load_cnt[load_board[i][j]] + 5'd1;
      end
    end
    for (int k = 1; k <= 5; k++)
      load_total = load_total + {2'b00, load_cnt[k]};
  end

  // A legal fleet has at most 15 cells; saturate rather than wrap otherwise.
  assign load_cells = (load_total > 7'd15) ? 4'd15 : load_total[3:0];

  // Shot evaluation on the latched coordinates.
  logic        in_range;
  logic [2:0]  row_i;
  logic [2:0]  col_i;
  logic [1:0]  tgt_map;
  logic [2:0]  tgt_kind;
  logic        shot_invalid;
  logic        fire_edge;

  assign in_range     = (row_q <= 4'd4) && (col_q <= 4'd4);
  assign row_i        = row_q[2:0];
  assign col_i        = col_q[2:0];
  assign tgt_map      = in_range ? map_q[row_i][col_i]   : 2'd0;
  assign tgt_kind     = in_range ? board_q[row_i][col_i] : 3'd0;
  assign shot_invalid = !in_range || (tgt_map != 2'd0);
  assign fire_edge    = disparar && !disparar_prev;

  always_comb begin
    matrizDisparosJ = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        matrizDisparosJ[i][j] = {30'd0, map_q[i][j]};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      disparar_prev      <= 1'b0;
      row_q              <= 4'd0;
      col_q              <= 4'd0;
      map_q              <= '0;
      rest_q             <= '0;
      resultadoValido    <= 1'b0;
      impacto            <= 1'b0;
      agua               <= 1'b0;
      hundido            <= 1'b0;
      disparoInvalido    <= 1'b0;
      tipoHundido        <= 3'd0;
      celdasRestantes    <= 4'd0;
      disparosRealizados <= 5'd0;
      juegoTerminado     <= 1'b0;
      // NOTE: board_q is deliberately not reset; it is always rewritten in
      // LOAD before EVAL can read it, so resetting it would only cost flops.
    end else begin
      disparar_prev   <= disparar;

      // Result pulses live for exactly one cycle unless EVAL sets them.
      resultadoValido <= 1'b0;
      impacto         <= 1'b0;
      agua            <= 1'b0;
      hundido         <= 1'b0;
      disparoInvalido <= 1'b0;
      tipoHundido     <= 3'd0;

      // Dropping the enable aborts whatever is in flight, including a shot
      // whose edge arrives in the same cycle; map and counters are kept.
      if (state != S_IDLE && !disparoHabilitado) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (disparoHabilitado) begin
              state          <= S_LOAD;
              juegoTerminado <= 1'b0;
            end
          end

          S_LOAD: begin
            board_q            <= load_board;
            map_q              <= '0;
            rest_q             <= load_cnt;
            celdasRestantes    <= load_cells;
            disparosRealizados <= 5'd0;
            if (load_cells == 4'd0) begin
              state          <= S_DONE;
              juegoTerminado <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (fire_edge) begin
              row_q <= fila;
              col_q <= columna;
              state <= S_EVAL;
            end
          end

          S_EVAL: begin
            state <= S_REPORT;
            if (shot_invalid) begin
              disparoInvalido <= 1'b1;
            end else if (tgt_kind == 3'd0) begin
              map_q[row_i][col_i] <= 2'd1;
              agua                <= 1'b1;
              resultadoValido     <= 1'b1;
              disparosRealizados  <= disparosRealizados + 5'd1;
            end else begin
              map_q[row_i][col_i] <= 2'd2;
              impacto             <= 1'b1;
              resultadoValido     <= 1'b1;
              disparosRealizados  <= disparosRealizados + 5'd1;
              if (rest_q[tgt_kind] != 5'd0)
                rest_q[tgt_kind] <= rest_q[tgt_kind] - 5'd1;
              if (celdasRestantes != 4'd0)
                celdasRestantes <= celdasRestantes - 4'd1;
              if (celdasRestantes == 4'd1)
                juegoTerminado <= 1'b1;
              // Last cell of this ship: mark the whole ship sunk. These later
              // assignments override the hit value written above.
              if (rest_q[tgt_kind] == 5'd1) begin
                hundido     <= 1'b1;
                tipoHundido <= tgt_kind;
                for (int i = 0; i < 5; i++)
                  for (int j = 0; j < 5; j++)
                    if (board_q[i][j] == tgt_kind)
                      map_q[i][j] <= 2'd3;
              end
            end
          end

          S_REPORT: begin
            state <= juegoTerminado ? S_DONE : S_WAIT;
          end

          S_DONE: begin
            state <= S_DONE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_procesar_disparo.sv
// Directed self-checking bench for procesar_disparo.
module tb_procesar_disparo;

  logic                  clk;
  logic                  reset;
  logic                  disparoHabilitado;
  logic                  disparar;
  logic [3:0]            fila;
  logic [3:0]            columna;
  logic [4:0][4:0][31:0] matrizJ;
  logic [4:0][4:0][31:0] matrizDisparosJ;
  logic                  resultadoValido;
  logic                  impacto;
  logic                  agua;
  logic                  hundido;
  logic                  disparoInvalido;
  logic [2:0]            tipoHundido;
  logic [3:0]            celdasRestantes;
  logic [4:0]            disparosRealizados;
  logic                  juegoTerminado;

  procesar_disparo dut (
    .clk                (clk),
    .reset              (reset),
    .disparoHabilitado  (disparoHabilitado),
    .disparar           (disparar),
    .fila               (fila),
    .columna            (columna),
    .matrizJ            (matrizJ),
    .matrizDisparosJ    (matrizDisparosJ),
    .resultadoValido    (resultadoValido),
    .impacto            (impacto),
    .agua               (agua),
    .hundido            (hundido),
    .disparoInvalido    (disparoInvalido),
    .tipoHundido        (tipoHundido),
    .celdasRestantes    (celdasRestantes),
    .disparosRealizados (disparosRealizados),
    .juegoTerminado     (juegoTerminado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse vector order: {resultadoValido, impacto, agua, hundido, disparoInvalido}
  logic [4:0] pulses;
  assign pulses = {resultadoValido, impacto, agua, hundido, disparoInvalido};

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_MISS = 5'b10100;
  localparam logic [4:0] P_HIT  = 5'b11000;
  localparam logic [4:0] P_SUNK = 5'b11010;
  localparam logic [4:0] P_INV  = 5'b00001;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One shot: edge cycle, EVAL sample, REPORT sample, then back to WAIT.
  task automatic fire(input int r, input int c,
                      output logic [4:0] p_eval, output logic [4:0] p_rep,
                      output logic [2:0] tipo_rep);
    fila     = 4'(r);
    columna  = 4'(c);
    disparar = 1'b1;
    tick();
    p_eval   = pulses;
    tick();
    p_rep    = pulses;
    tipo_rep = tipoHundido;
    disparar = 1'b0;
    tick();
  endtask

  logic [4:0] pe;
  logic [4:0] pr;
  logic [2:0] tr;
  int         pulse_count;
  int         shots;
  logic       sunk;

  initial begin
    reset             = 1'b1;
    disparoHabilitado = 1'b0;
    disparar          = 1'b0;
    fila              = 4'd0;
    columna           = 4'd0;
    matrizJ           = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_pulses", 32'(pulses), 32'(P_NONE));
    check("rst_celdas", 32'(celdasRestantes), 32'd0);
    check("rst_disparos", 32'(disparosRealizados), 32'd0);
    check("rst_juego", 32'(juegoTerminado), 32'd0);
    check("rst_tipo", 32'(tipoHundido), 32'd0);
    check("rst_map", matrizDisparosJ[0][4], 32'd0);

    // ---------------- Game 1: single 2-ship at (0,3),(0,4)
    matrizJ       = '0;
    matrizJ[0][3] = 32'd2;
    matrizJ[0][4] = 32'd2;
    disparoHabilitado = 1'b1;
    tick();  // LOAD
    tick();  // WAIT
    check("g1_load_celdas", 32'(celdasRestantes), 32'd2);

    fire(0, 4, pe, pr, tr);
    check("g1_hit_eval_quiet", 32'(pe), 32'(P_NONE));
    check("g1_hit_pulse", 32'(pr), 32'(P_HIT));
    check("g1_hit_after", 32'(pulses), 32'(P_NONE));
    check("g1_hit_map", matrizDisparosJ[0][4], 32'd2);
    check("g1_hit_celdas", 32'(celdasRestantes), 32'd1);
    check("g1_hit_juego", 32'(juegoTerminado), 32'd0);

    fire(0, 3, pe, pr, tr);
    check("g1_sunk_pulse", 32'(pr), 32'(P_SUNK));
    check("g1_sunk_tipo", 32'(tr), 32'd2);
    check("g1_sunk_map03", matrizDisparosJ[0][3], 32'd3);
    check("g1_sunk_map04", matrizDisparosJ[0][4], 32'd3);
    check("g1_sunk_celdas", 32'(celdasRestantes), 32'd0);
    check("g1_sunk_juego", 32'(juegoTerminado), 32'd1);
    check("g1_sunk_disparos", 32'(disparosRealizados), 32'd2);

    fire(2, 2, pe, pr, tr);  // DONE ignores the button
    check("g1_done_eval", 32'(pe), 32'(P_NONE));
    check("g1_done_rep", 32'(pr), 32'(P_NONE));
    check("g1_done_disparos", 32'(disparosRealizados), 32'd2);
    check("g1_done_map22", matrizDisparosJ[2][2], 32'd0);

    disparoHabilitado = 1'b0;
    tick();  // IDLE
    check("g1_idle_juego_kept", 32'(juegoTerminado), 32'd1);

    // ---------------- Game 2: 2-ship + 3-ship, plus out-of-range values
    matrizJ       = '0;
    matrizJ[0][3] = 32'd2;
    matrizJ[0][4] = 32'd2;
    matrizJ[4][0] = 32'd3;
    matrizJ[4][1] = 32'd3;
    matrizJ[4][2] = 32'd3;
    matrizJ[1][1] = 32'd7;           // water
    matrizJ[3][3] = 32'hFFFF_FFFF;   // -1, water
    disparoHabilitado = 1'b1;
    tick();  // LOAD
    check("g2_load_juego_clr", 32'(juegoTerminado), 32'd0);
    tick();  // WAIT
    check("g2_load_celdas", 32'(celdasRestantes), 32'd5);
    check("g2_load_disparos", 32'(disparosRealizados), 32'd0);
    check("g2_load_map_clr", matrizDisparosJ[0][4], 32'd0);

    fire(2, 2, pe, pr, tr);
    check("g2_miss_pulse", 32'(pr), 32'(P_MISS));
    check("g2_miss_map", matrizDisparosJ[2][2], 32'd1);
    check("g2_miss_disparos", 32'(disparosRealizados), 32'd1);

    fire(2, 2, pe, pr, tr);
    check("g2_repeat_pulse", 32'(pr), 32'(P_INV));
    check("g2_repeat_map", matrizDisparosJ[2][2], 32'd1);
    check("g2_repeat_disparos", 32'(disparosRealizados), 32'd1);

    fire(5, 0, pe, pr, tr);
    check("g2_fila5_pulse", 32'(pr), 32'(P_INV));
    check("g2_fila5_disparos", 32'(disparosRealizados), 32'd1);
    check("g2_fila5_celdas", 32'(celdasRestantes), 32'd5);

    // Held button: ten cycles high, exactly one result pulse.
    fila        = 4'd1;
    columna     = 4'd1;
    disparar    = 1'b1;
    pulse_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resultadoValido || disparoInvalido) pulse_count++;
    end
    disparar = 1'b0;
    tick();
    check("g2_held_one_pulse", 32'(pulse_count), 32'd1);
    check("g2_held_map_water7", matrizDisparosJ[1][1], 32'd1);
    check("g2_held_disparos", 32'(disparosRealizados), 32'd2);

    fire(4, 0, pe, pr, tr);
    check("g2_hit3_pulse", 32'(pr), 32'(P_HIT));
    check("g2_hit3_celdas", 32'(celdasRestantes), 32'd4);

    // Disable while the shot is in EVAL: shot discarded, state retained.
    fila     = 4'd4;
    columna  = 4'd1;
    disparar = 1'b1;
    tick();  // EVAL
    disparoHabilitado = 1'b0;
    tick();  // IDLE
    check("g2_abort_pulse", 32'(pulses), 32'(P_NONE));
    disparar = 1'b0;
    tick();
    check("g2_abort_pulse2", 32'(pulses), 32'(P_NONE));
    check("g2_abort_map41", matrizDisparosJ[4][1], 32'd0);
    check("g2_abort_map40", matrizDisparosJ[4][0], 32'd2);
    check("g2_abort_celdas", 32'(celdasRestantes), 32'd4);
    check("g2_abort_disparos", 32'(disparosRealizados), 32'd3);

    // ---------------- Game 3: full 15-cell board, row r holds ship 5-r
    matrizJ = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5 - r; c++)
        matrizJ[r][c] = 32'(5 - r);
    disparoHabilitado = 1'b1;
    tick();
    tick();
    check("g3_load_celdas", 32'(celdasRestantes), 32'd15);

    // Edge and disable in the same cycle: disable wins.
    fila              = 4'd0;
    columna           = 4'd0;
    disparar          = 1'b1;
    disparoHabilitado = 1'b0;
    tick();
    tick();
    tick();
    check("g3_same_cycle_pulse", 32'(pulses), 32'(P_NONE));
    check("g3_same_cycle_map", matrizDisparosJ[0][0], 32'd0);
    check("g3_same_cycle_celdas", 32'(celdasRestantes), 32'd15);
    disparar          = 1'b0;
    disparoHabilitado = 1'b1;
    tick();
    tick();

    shots = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5 - r; c++) begin
        fire(r, c, pe, pr, tr);
        shots++;
        sunk = (c == 4 - r);
        check($sformatf("g3_pulse_%0d_%0d", r, c), 32'(pr), 32'(sunk ? P_SUNK : P_HIT));
        check($sformatf("g3_celdas_%0d_%0d", r, c), 32'(celdasRestantes), 32'(15 - shots));
        if (sunk)
          check($sformatf("g3_tipo_%0d", r), 32'(tr), 32'(5 - r));
      end
    end
    check("g3_juego", 32'(juegoTerminado), 32'd1);
    check("g3_map_sunk14", matrizDisparosJ[1][3], 32'd3);
    fire(4, 4, pe, pr, tr);
    check("g3_16th_pulse", 32'(pr | pe), 32'(P_NONE));
    check("g3_16th_disparos", 32'(disparosRealizados), 32'd15);

    // ---------------- Reset in the EVAL cycle
    disparoHabilitado = 1'b0;
    tick();
    disparoHabilitado = 1'b1;
    tick();
    tick();
    fila     = 4'd0;
    columna  = 4'd0;
    disparar = 1'b1;
    tick();  // EVAL
    reset = 1'b1;
    tick();
    check("rst_eval_pulses", 32'(pulses), 32'(P_NONE));
    check("rst_eval_celdas", 32'(celdasRestantes), 32'd0);
    check("rst_eval_disparos", 32'(disparosRealizados), 32'd0);
    check("rst_eval_juego", 32'(juegoTerminado), 32'd0);
    check("rst_eval_map", matrizDisparosJ[0][0], 32'd0);
    reset             = 1'b0;
    disparar          = 1'b0;
    disparoHabilitado = 1'b0;
    tick();
    tick();
    check("rst_eval_quiet", 32'(pulses), 32'(P_NONE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
